// File: rtl/panel_input_conditioner.sv
// panel_input_conditioner: synchronise, debounce and edge-detect front-panel buttons and switches
module panel_input_conditioner #(
    parameter int N_BTN           = 3,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic             clock,
    input  logic             reset_N,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_SW-1:0]  sw_level,
    output logic             sw_change
);
    localparam int N  = N_BTN + N_SW;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]    CMAX     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_BTN-1:0] BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [N_BTN-1:0] btn_s1, btn_s2;
    logic [N_SW-1:0]  sw_s1, sw_s2;
    logic [N-1:0]     smp, lvl, upd;
    logic [CW-1:0]    cnt [N];

    // two-flop synchronisers; buttons idle at their released pin value
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            btn_s1 <= BTN_IDLE;
            btn_s2 <= BTN_IDLE;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= sw_raw;
            sw_s2  <= sw_s1;
        end
    end

    assign smp = {sw_s2, (BTN_ACTIVE_LOW != 0) ? ~btn_s2 : btn_s2};

    // a channel flips once its sample has disagreed with the level for the full window
    always_comb begin
        upd = '0;
        for (int i = 0; i < N; i++)
            upd[i] = (smp[i] != lvl[i]) && (cnt[i] == CMAX);
    end

    // per-channel run counters, stable levels and registered edge pulses
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            for (int i = 0; i < N; i++)
                cnt[i] <= '0;
            lvl         <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            sw_change   <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++)
                cnt[i] <= (smp[i] == lvl[i] || upd[i]) ? '0 : cnt[i] + 1'b1;
            lvl         <= lvl ^ upd;
            btn_press   <= upd[N_BTN-1:0] & smp[N_BTN-1:0];
            btn_release <= upd[N_BTN-1:0] & ~smp[N_BTN-1:0];
            sw_change   <= |upd[N-1:N_BTN];
        end
    end

    assign btn_level = lvl[N_BTN-1:0];
    assign sw_level  = lvl[N-1:N_BTN];
endmodule

// File: tb/tb_panel_input_conditioner.sv
// tb_panel_input_conditioner: directed checks of debounce latency, pulses, bounce rejection and reset
module tb_panel_input_conditioner;
    logic       clock = 1'b0;
    logic       reset_N;
    logic [2:0] btn_raw;
    logic [9:0] sw_raw;
    logic [2:0] btn_level, btn_press, btn_release;
    logic [9:0] sw_level;
    logic       sw_change;
    int checks = 0;
    int failures = 0;

    panel_input_conditioner #(.N_BTN(3), .N_SW(10), .DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(1)) dut (
        .clock(clock), .reset_N(reset_N), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .sw_level(sw_level), .sw_change(sw_change)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_N = 1'b0;
        btn_raw = 3'b000;
        sw_raw  = 10'h000;
        repeat (3) tick();
        checks++;
        if ({btn_level, btn_press, btn_release, sw_level, sw_change} !== 20'd0) begin
            failures++;
            $display("FAIL reset_outputs got lvl=%b prs=%b rel=%b sw=%h chg=%b exp all 0",
                     btn_level, btn_press, btn_release, sw_level, sw_change);
        end
        reset_N = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (btn_press !== (e == 6 ? 3'b111 : 3'b000) || btn_level !== (e >= 6 ? 3'b111 : 3'b000)) begin
                failures++;
                $display("FAIL reset_held_press edge=%0d got lvl=%b prs=%b exp lvl=%b prs=%b",
                         e, btn_level, btn_press, (e >= 6 ? 3'b111 : 3'b000), (e == 6 ? 3'b111 : 3'b000));
            end
        end
        btn_raw = 3'b111;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (btn_release !== (e == 6 ? 3'b111 : 3'b000)) begin
                failures++;
                $display("FAIL reset_release_all edge=%0d got %b exp %b", e, btn_release, (e == 6 ? 3'b111 : 3'b000));
            end
        end
    endtask

    task automatic test_press_release();
        btn_raw = 3'b110;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (btn_press !== (e == 6 ? 3'b001 : 3'b000) || btn_release !== 3'b000) begin
                failures++;
                $display("FAIL press0 edge=%0d got prs=%b rel=%b exp prs=%b rel=000",
                         e, btn_press, btn_release, (e == 6 ? 3'b001 : 3'b000));
            end
        end
        checks++;
        if (btn_level !== 3'b001) begin
            failures++;
            $display("FAIL press0_level got %b exp 001", btn_level);
        end
        btn_raw = 3'b111;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (btn_release !== (e == 6 ? 3'b001 : 3'b000) || btn_press !== 3'b000) begin
                failures++;
                $display("FAIL release0 edge=%0d got rel=%b prs=%b exp rel=%b prs=000",
                         e, btn_release, btn_press, (e == 6 ? 3'b001 : 3'b000));
            end
        end
        checks++;
        if (btn_level !== 3'b000) begin
            failures++;
            $display("FAIL release0_level got %b exp 000", btn_level);
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        pat = 6'b100010;
        for (int k = 0; k < 6; k++) begin
            btn_raw = {pat[k], 2'b11};
            tick();
        end
        for (int e = 0; e < 8; e++) begin
            tick();
            checks++;
            if (btn_level !== 3'b000 || btn_press !== 3'b000 || btn_release !== 3'b000) begin
                failures++;
                $display("FAIL bounce_quiet cyc=%0d got lvl=%b prs=%b rel=%b exp all 000",
                         e, btn_level, btn_press, btn_release);
            end
        end
        btn_raw = 3'b011;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (btn_press !== (e == 6 ? 3'b100 : 3'b000)) begin
                failures++;
                $display("FAIL bounce_then_press edge=%0d got %b exp %b", e, btn_press, (e == 6 ? 3'b100 : 3'b000));
            end
        end
        btn_raw = 3'b111;
        repeat (8) tick();
    endtask

    task automatic test_switches();
        int pulses;
        sw_raw = 10'h203;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (sw_change !== (e == 6) || sw_level !== (e >= 6 ? 10'h203 : 10'h000)) begin
                failures++;
                $display("FAIL sw_step edge=%0d got lvl=%h chg=%b exp lvl=%h chg=%b",
                         e, sw_level, sw_change, (e >= 6 ? 10'h203 : 10'h000), (e == 6));
            end
        end
        pulses = 0;
        sw_raw = 10'h207;
        for (int e = 1; e <= 10; e++) begin
            if (e == 3) sw_raw = 10'h20F;
            tick();
            pulses += int'(sw_change);
            checks++;
            if (sw_change !== (e == 6 || e == 8)) begin
                failures++;
                $display("FAIL sw_stagger edge=%0d got chg=%b exp %b", e, sw_change, (e == 6 || e == 8));
            end
        end
        checks++;
        if (pulses != 2 || sw_level !== 10'h20F) begin
            failures++;
            $display("FAIL sw_stagger_total got pulses=%0d lvl=%h exp pulses=2 lvl=20f", pulses, sw_level);
        end
    endtask

    task automatic test_reset_mid_count();
        btn_raw = 3'b101;
        repeat (3) tick();
        reset_N = 1'b0;
        #1;
        checks++;
        if (btn_level !== 3'b000 || btn_press !== 3'b000 || sw_level !== 10'h000) begin
            failures++;
            $display("FAIL midreset_clear got lvl=%b prs=%b sw=%h exp 000 000 000", btn_level, btn_press, sw_level);
        end
        for (int e = 0; e < 5; e++) begin
            tick();
            checks++;
            if (btn_press !== 3'b000 || btn_level !== 3'b000) begin
                failures++;
                $display("FAIL midreset_hold cyc=%0d got lvl=%b prs=%b exp 000 000", e, btn_level, btn_press);
            end
        end
        reset_N = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (btn_press !== (e == 6 ? 3'b010 : 3'b000)) begin
                failures++;
                $display("FAIL midreset_redetect edge=%0d got %b exp %b", e, btn_press, (e == 6 ? 3'b010 : 3'b000));
            end
        end
    endtask

    task automatic test_back_to_back();
        btn_raw = 3'b001;
        repeat (8) tick();
        checks++;
        if (btn_level !== 3'b110) begin
            failures++;
            $display("FAIL b2b_setup got %b exp 110", btn_level);
        end
        btn_raw = 3'b100;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (btn_press !== (e == 6 ? 3'b001 : 3'b000) || btn_release !== (e == 6 ? 3'b100 : 3'b000)) begin
                failures++;
                $display("FAIL b2b edge=%0d got prs=%b rel=%b exp prs=%b rel=%b", e, btn_press, btn_release,
                         (e == 6 ? 3'b001 : 3'b000), (e == 6 ? 3'b100 : 3'b000));
            end
        end
        checks++;
        if (btn_level !== 3'b011) begin
            failures++;
            $display("FAIL b2b_level got %b exp 011", btn_level);
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_switches();
        test_reset_mid_count();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
